// File: rtl/fixed_pkg.sv
// Shared definitions for the signed fixed-point divider: default Q8.8 widths,
// controller state encoding and the iteration-count helper.
package fixed_pkg;

  localparam int Q_DATA_WIDTH = 16;
  localparam int Q_FRAC_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

  // One quotient bit per iteration, plus a guard bit when rounding is enabled.
  function automatic int div_iterations(input int data_width, input int frac_width,
                                        input bit round_en);
    return data_width + frac_width + (round_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division step: shift in the next numerator bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module fixed_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // rem_in < divisor, so the true difference always fits in WIDTH bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    diff    = shifted[WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_div.sv
// Signed fixed-point divider (restoring radix-2, one quotient bit per cycle) with
// saturation and divide-by-zero flagging. Define FIXED_DIV_ROUND_EN for round-half-up.
module fixed_div
  import fixed_pkg::*;
#(
  parameter int DATA_WIDTH = Q_DATA_WIDTH,
  parameter int FRAC_WIDTH = Q_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  div_by_zero
);

`ifdef FIXED_DIV_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int ITERS = div_iterations(DATA_WIDTH, FRAC_WIDTH, ROUND_EN);
  localparam int GUARD = ITERS - DATA_WIDTH;
  localparam int CNT_W = $clog2(ITERS + 1);

  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ITERS-1:0] POS_LIM = {{(GUARD+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ITERS-1:0] NEG_LIM = POS_LIM + 1'b1;

  div_state_e            state;
  logic [CNT_W-1:0]      iter_cnt;
  logic [DATA_WIDTH-1:0] rem;
  logic [ITERS-1:0]      num;
  logic [ITERS-1:0]      quo;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic                  res_neg;
  logic                  dvd_neg;
  logic                  zero_div;

  logic [DATA_WIDTH-1:0] dvd_abs;
  logic [DATA_WIDTH-1:0] dvs_abs;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic [ITERS-1:0]      q_mag;
  logic [DATA_WIDTH-1:0] fin_result;
  logic                  fin_ovf;
  logic                  accept;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  // Magnitudes are unsigned, so the most-negative input maps to 2^(DATA_WIDTH-1).
  always_comb begin
    dvd_abs = dividend[DATA_WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_abs = divisor[DATA_WIDTH-1] ? (~divisor + 1'b1) : divisor;
  end

  fixed_div_step #(
    .WIDTH (DATA_WIDTH)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (num[ITERS-1]),
    .divisor (dvs_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

`ifdef FIXED_DIV_ROUND_EN
  assign q_mag = {1'b0, quo[ITERS-1:1]} + {{(ITERS-1){1'b0}}, quo[0]};
`else
  assign q_mag = quo;
`endif

  // Saturation limits are asymmetric: negative results may reach 2^(DATA_WIDTH-1).
  always_comb begin
    fin_result = '0;
    fin_ovf    = 1'b0;
    if (zero_div) begin
      fin_result = dvd_neg ? RES_MIN : RES_MAX;
      fin_ovf    = 1'b1;
    end else if (res_neg) begin
      if (q_mag > NEG_LIM) begin
        fin_result = RES_MIN;
        fin_ovf    = 1'b1;
      end else begin
        fin_result = ~q_mag[DATA_WIDTH-1:0] + 1'b1;
      end
    end else begin
      if (q_mag > POS_LIM) begin
        fin_result = RES_MAX;
        fin_ovf    = 1'b1;
      end else begin
        fin_result = q_mag[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      iter_cnt    <= '0;
      rem         <= '0;
      num         <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      zero_div    <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            iter_cnt <= '0;
            rem      <= '0;
            quo      <= '0;
            num      <= {dvd_abs, {GUARD{1'b0}}};
            dvs_mag  <= dvs_abs;
            res_neg  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            dvd_neg  <= dividend[DATA_WIDTH-1];
            zero_div <= (divisor == '0);
            state    <= (divisor == '0) ? ST_FINISH : ST_CALC;
          end
        end
        ST_CALC: begin
          rem      <= step_rem;
          num      <= {num[ITERS-2:0], 1'b0};
          quo      <= {quo[ITERS-2:0], step_q};
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == CNT_W'(ITERS - 1)) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          result      <= fin_result;
          overflow    <= fin_ovf;
          div_by_zero <= zero_div;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
